// File: rtl/key_pkg.sv
// Shared definitions for the key conditioner: per-channel FSM encoding and
// width helpers used to size the debounce and hold/repeat counters.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_WAIT = 2'd1,
        HELD       = 2'd2,
        REL_WAIT   = 2'd3
    } key_state_e;

    // Bits needed to count 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-FF synchroniser, debounce FSM, long-press and
// auto-repeat counters. Every output is a register.
// The pulse ports are release_pulse / repeat_pulse because release and
// repeat are reserved words.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int DELAY      = 1000000,
    parameter int LONG       = 50000000,
    parameter int REPEAT     = 10000000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic long_press,
    output logic repeat_pulse
);

    localparam int CW = clog2(DELAY);
    localparam int HW = clog2(max3(LONG, REPEAT, 2));
    localparam int REP_LAST_I = (REPEAT > 0) ? REPEAT - 1 : 0;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DELAY - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG - 1);
    localparam logic [HW-1:0] REP_LAST  = HW'(REP_LAST_I);
    // Raw pin level when the key is not pressed.
    localparam logic IDLE_RAW = 1'(ACTIVE_LOW != 0);

    logic sync1, sync2, ks;
    key_state_e state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [HW-1:0] hold, hold_n, rep, rep_n;
    logic long_done, long_done_n;
    logic level_n, press_n, release_n, long_n, repeat_n;

    // Pressed = 1 regardless of pin polarity.
    assign ks = (ACTIVE_LOW != 0) ? ~sync2 : sync2;

    // State, counters, synchroniser and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1         <= IDLE_RAW;
            sync2         <= IDLE_RAW;
            state         <= IDLE;
            cnt           <= '0;
            hold          <= '0;
            rep           <= '0;
            long_done     <= 1'b0;
            level         <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            sync1         <= key;
            sync2         <= sync1;
            state         <= state_n;
            cnt           <= cnt_n;
            hold          <= hold_n;
            rep           <= rep_n;
            long_done     <= long_done_n;
            level         <= level_n;
            press         <= press_n;
            release_pulse <= release_n;
            long_press    <= long_n;
            repeat_pulse  <= repeat_n;
        end
    end

    // Next-state, counter updates and next values of the registered pulses.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        hold_n      = hold;
        rep_n       = rep;
        long_done_n = long_done;
        level_n     = level;
        press_n     = 1'b0;
        release_n   = 1'b0;
        long_n      = 1'b0;
        repeat_n    = 1'b0;
        case (state)
            IDLE: begin
                if (ks) begin
                    state_n = PRESS_WAIT;
                    cnt_n   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!ks) begin
                    state_n = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_n     = HELD;
                    press_n     = 1'b1;
                    level_n     = 1'b1;
                    hold_n      = '0;
                    rep_n       = '0;
                    long_done_n = 1'b0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            HELD: begin
                // Hold stops counting once long_press has fired, which
                // is how it saturates; repeat only runs after that.
                if (!long_done) begin
                    if (hold == HOLD_LAST) begin
                        long_n      = 1'b1;
                        long_done_n = 1'b1;
                    end else begin
                        hold_n = hold + HW'(1);
                    end
                end else if (REPEAT > 0) begin
                    if (rep == REP_LAST) begin
                        repeat_n = 1'b1;
                        rep_n    = '0;
                    end else begin
                        rep_n = rep + HW'(1);
                    end
                end
                // Leaving HELD does not cancel a pulse due this cycle.
                if (!ks) begin
                    state_n = REL_WAIT;
                    cnt_n   = '0;
                end
            end
            REL_WAIT: begin
                if (ks) begin
                    state_n = HELD;
                end else if (cnt == CNT_LAST) begin
                    state_n   = IDLE;
                    release_n = 1'b1;
                    level_n   = 1'b0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: rtl/key_debounce_n.sv
// N-channel push-button conditioner: one independent key_debounce_ch per
// key pin, outputs packed by channel index.
module key_debounce_n
    import key_pkg::*;
#(
    parameter int N          = 4,
    parameter int DELAY      = 1000000,
    parameter int LONG       = 50000000,
    parameter int REPEAT     = 10000000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] key,
    output logic [N-1:0] level,
    output logic [N-1:0] press,
    output logic [N-1:0] release_pulse,
    output logic [N-1:0] long_press,
    output logic [N-1:0] repeat_pulse
);

    for (genvar i = 0; i < N; i++) begin : g_ch
        key_debounce_ch #(
            .DELAY      (DELAY),
            .LONG       (LONG),
            .REPEAT     (REPEAT),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .key           (key[i]),
            .level         (level[i]),
            .press         (press[i]),
            .release_pulse (release_pulse[i]),
            .long_press    (long_press[i]),
            .repeat_pulse  (repeat_pulse[i])
        );
    end

endmodule

// File: tb/tb_key_debounce_n.sv
// Directed bench for key_debounce_n (DELAY=4, LONG=20, REPEAT=6, active-low).
// Scenarios are tables of stimulus segments plus a table of expected pulse
// events; every cycle of a scenario compares all outputs of both instances.
module tb_key_debounce_n;

    localparam int N      = 4;
    localparam int DELAY  = 4;
    localparam int LONG   = 20;
    localparam int REPEAT = 6;

    localparam int EV_PRESS   = 0;
    localparam int EV_RELEASE = 1;
    localparam int EV_LONG    = 2;
    localparam int EV_REPEAT  = 3;
    localparam int EV_RST     = 4;

    typedef struct {
        logic [N-1:0] key;
        logic         rst;
        int           len;
    } seg_t;

    typedef struct {
        int cyc;
        int ch;
        int kind;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0] key;
    logic [N-1:0] level, press, release_pulse, long_press, repeat_pulse;
    logic [0:0] key_nr;
    logic [0:0] level_nr, press_nr, release_nr, long_nr, repeat_nr;

    int checks = 0;
    int errors = 0;

    seg_t seg_q[$];
    ev_t  ev_q[$];
    logic [N-1:0] lvl_exp;

    // clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    key_debounce_n #(
        .N(N), .DELAY(DELAY), .LONG(LONG), .REPEAT(REPEAT), .ACTIVE_LOW(1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .key           (key),
        .level         (level),
        .press         (press),
        .release_pulse (release_pulse),
        .long_press    (long_press),
        .repeat_pulse  (repeat_pulse)
    );

    key_debounce_n #(
        .N(1), .DELAY(DELAY), .LONG(LONG), .REPEAT(0), .ACTIVE_LOW(1)
    ) dut_nr (
        .clk           (clk),
        .rst           (rst),
        .key           (key_nr),
        .level         (level_nr),
        .press         (press_nr),
        .release_pulse (release_nr),
        .long_press    (long_nr),
        .repeat_pulse  (repeat_nr)
    );

    task automatic add_seg(input logic [N-1:0] k, input logic r, input int len);
        seg_t s;
        s.key = k;
        s.rst = r;
        s.len = len;
        seg_q.push_back(s);
    endtask

    task automatic add_ev(input int cyc, input int ch, input int kind);
        ev_t e;
        e.cyc  = cyc;
        e.ch   = ch;
        e.kind = kind;
        ev_q.push_back(e);
    endtask

    // Cycle c is the rising edge that first samples the c-th stimulus value.
    task automatic run_scenario(input string name);
        int c;
        logic [N-1:0] ep, er, el, et;
        c = 0;
        for (int si = 0; si < seg_q.size(); si++) begin
            for (int j = 0; j < seg_q[si].len; j++) begin
                @(negedge clk);
                key = seg_q[si].key;
                rst = seg_q[si].rst;
                @(posedge clk);
                #1;
                ep = '0; er = '0; el = '0; et = '0;
                foreach (ev_q[e]) begin
                    if (ev_q[e].cyc == c) begin
                        case (ev_q[e].kind)
                            EV_PRESS:   begin ep[ev_q[e].ch] = 1'b1; lvl_exp[ev_q[e].ch] = 1'b1; end
                            EV_RELEASE: begin er[ev_q[e].ch] = 1'b1; lvl_exp[ev_q[e].ch] = 1'b0; end
                            EV_LONG:    el[ev_q[e].ch] = 1'b1;
                            EV_REPEAT:  et[ev_q[e].ch] = 1'b1;
                            default:    lvl_exp = '0;
                        endcase
                    end
                end
                checks++;
                if ({level, press, release_pulse, long_press, repeat_pulse,
                     level_nr, press_nr, release_nr, long_nr, repeat_nr} !==
                    {lvl_exp, ep, er, el, et, 5'b0}) begin
                    errors++;
                    $display("FAIL %s cycle %0d: got level=%b press=%b release=%b long=%b repeat=%b nr=%b%b%b%b%b, want level=%b press=%b release=%b long=%b repeat=%b nr=00000",
                             name, c, level, press, release_pulse, long_press, repeat_pulse,
                             level_nr, press_nr, release_nr, long_nr, repeat_nr,
                             lvl_exp, ep, er, el, et);
                end
                c++;
            end
        end
        seg_q.delete();
        ev_q.delete();
    endtask

    // stimulus, checks and final report
    initial begin
        int long_cnt, rpt_cnt, long_at, rel_at;

        rst     = 1'b1;
        key     = '1;
        key_nr  = 1'b1;
        lvl_exp = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({level, press, release_pulse, long_press, repeat_pulse,
             level_nr, press_nr, release_nr, long_nr, repeat_nr} !== 25'b0) begin
            errors++;
            $display("FAIL reset_state: got %b, want all zero",
                     {level, press, release_pulse, long_press, repeat_pulse,
                      level_nr, press_nr, release_nr, long_nr, repeat_nr});
        end

        // Long hold on key 0: press, long_press, two repeats, release.
        add_seg(4'b1110, 1'b0, 40);
        add_seg(4'b1111, 1'b0, 10);
        add_ev(6, 0, EV_PRESS);
        add_ev(26, 0, EV_LONG);
        add_ev(32, 0, EV_REPEAT);
        add_ev(38, 0, EV_REPEAT);
        add_ev(46, 0, EV_RELEASE);
        run_scenario("long_hold");

        // Release seen by HELD on the same edge a repeat falls due.
        add_seg(4'b1110, 1'b0, 30);
        add_seg(4'b1111, 1'b0, 10);
        add_ev(6, 0, EV_PRESS);
        add_ev(26, 0, EV_LONG);
        add_ev(32, 0, EV_REPEAT);
        add_ev(36, 0, EV_RELEASE);
        run_scenario("exit_with_repeat");

        // Key 1 bounces with 2-cycle phases: nothing may come out.
        for (int i = 0; i < 5; i++) begin
            add_seg(4'b1101, 1'b0, 2);
            add_seg(4'b1111, 1'b0, 2);
        end
        add_seg(4'b1111, 1'b0, 10);
        run_scenario("bounce");

        // Key 2 release with a 2-cycle re-press glitch.
        add_seg(4'b1011, 1'b0, 10);
        add_seg(4'b1111, 1'b0, 3);
        add_seg(4'b1011, 1'b0, 2);
        add_seg(4'b1111, 1'b0, 12);
        add_ev(6, 2, EV_PRESS);
        add_ev(21, 2, EV_RELEASE);
        run_scenario("release_glitch");

        // Keys 0 and 3 together.
        add_seg(4'b0110, 1'b0, 10);
        add_seg(4'b1111, 1'b0, 10);
        add_ev(6, 0, EV_PRESS);
        add_ev(6, 3, EV_PRESS);
        add_ev(16, 0, EV_RELEASE);
        add_ev(16, 3, EV_RELEASE);
        run_scenario("simultaneous");

        // One-cycle reset while key 0 is held, then a fresh press.
        add_seg(4'b1110, 1'b0, 10);
        add_seg(4'b1110, 1'b1, 1);
        add_seg(4'b1110, 1'b0, 12);
        add_seg(4'b1111, 1'b0, 10);
        add_ev(6, 0, EV_PRESS);
        add_ev(10, 0, EV_RST);
        add_ev(17, 0, EV_PRESS);
        add_ev(29, 0, EV_RELEASE);
        run_scenario("mid_reset");

        // Repeat-disabled instance: one long_press, no repeats.
        long_cnt = 0;
        rpt_cnt  = 0;
        long_at  = -1;
        rel_at   = -1;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            rst    = 1'b0;
            key    = '1;
            key_nr = (c < 60) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
            if (long_nr[0]) begin long_cnt++; long_at = c; end
            if (repeat_nr[0]) rpt_cnt++;
            if (release_nr[0]) rel_at = c;
            if (c == 59) begin
                checks++;
                if (level_nr[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL nr_level_held: got %b, want 1", level_nr[0]);
                end
            end
        end
        checks++;
        if (long_cnt != 1) begin
            errors++;
            $display("FAIL nr_long_count: got %0d, want 1", long_cnt);
        end
        checks++;
        if (long_at != 26) begin
            errors++;
            $display("FAIL nr_long_cycle: got %0d, want 26", long_at);
        end
        checks++;
        if (rpt_cnt != 0) begin
            errors++;
            $display("FAIL nr_repeat_count: got %0d, want 0", rpt_cnt);
        end
        checks++;
        if (rel_at != 66) begin
            errors++;
            $display("FAIL nr_release_cycle: got %0d, want 66", rel_at);
        end
        checks++;
        if (level_nr[0] !== 1'b0) begin
            errors++;
            $display("FAIL nr_level_released: got %b, want 0", level_nr[0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
